// File: rtl/iir_multi_if.sv
// Stream, coefficient-write and clear signals of the time-multiplexed IIR filter.
// The filter uses the slave view; a source/sink driving it uses the master view.
interface iir_multi_if #(
    parameter int DW    = 24,
    parameter int COEFW = 18,
    parameter int CW    = 2,
    parameter int IW    = 3
);
    logic [DW-1:0]    s_axis_tdata;
    logic [CW-1:0]    s_axis_tid;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic [CW-1:0]    m_axis_tid;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             coef_wr_valid;
    logic             coef_wr_ready;
    logic [CW-1:0]    coef_wr_ch;
    logic [IW-1:0]    coef_wr_idx;
    logic [COEFW-1:0] coef_wr_data;
    logic             hist_clr;

    modport slave (
        input  s_axis_tdata, s_axis_tid, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tid, m_axis_tvalid,
        input  m_axis_tready,
        input  coef_wr_valid, coef_wr_ch, coef_wr_idx, coef_wr_data,
        output coef_wr_ready,
        input  hist_clr
    );

    modport master (
        output s_axis_tdata, s_axis_tid, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tid, m_axis_tvalid,
        output m_axis_tready,
        output coef_wr_valid, coef_wr_ch, coef_wr_idx, coef_wr_data,
        input  coef_wr_ready,
        output hist_clr
    );
endinterface

// File: rtl/iir_multi.sv
// Multi-channel direct-form IIR filter sharing one multiplier: one tap per cycle,
// then round/saturate, then hold the result until the sink takes it.
module iir_multi #(
    parameter int DW    = 24,
    parameter int COEFW = 18,
    parameter int COEFQ = 16,
    parameter int ORDER = 2,
    parameter int NCH   = 4,
    parameter int ROUND = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    iir_multi_if.slave  bus
);
    localparam int N    = 2 * ORDER + 1;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW   = $clog2(N);
    localparam int PW   = DW + COEFW;
    localparam int ACCW = DW + COEFW + IW;

    localparam logic signed [ACCW-1:0] RND_ONE = {{(ACCW-COEFQ){1'b0}}, 1'b1, {(COEFQ-1){1'b0}}};
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [COEFW-1:0] COEF_ONE = COEFW'(1) << COEFQ;

    typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_t;

    state_t r_state, w_state_next;

    logic signed [COEFW-1:0] r_coef [NCH][N];
    logic signed [DW-1:0]    r_xh   [NCH][ORDER];
    logic signed [DW-1:0]    r_yh   [NCH][ORDER];

    logic signed [DW-1:0]    r_x;
    logic [CW-1:0]           r_ch;
    logic [IW-1:0]           r_tap;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [DW-1:0]    r_out_data;
    logic [CW-1:0]           r_out_tid;

    logic                    w_idle, w_accept, w_in_range, w_coef_we;
    logic signed [DW-1:0]    w_opnd;
    logic signed [COEFW-1:0] w_coef;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACCW-1:0]  w_prod_ext, w_sum, w_shr;
    logic signed [DW-1:0]    w_sat;

    assign w_idle      = (r_state == IDLE);
    assign w_in_range  = (int'(bus.s_axis_tid) < NCH);
    assign w_accept    = bus.s_axis_tvalid && bus.s_axis_tready;
    assign w_coef_we   = w_idle && bus.coef_wr_valid &&
                         (int'(bus.coef_wr_idx) < N) && (int'(bus.coef_wr_ch) < NCH);

    assign bus.s_axis_tready = w_idle && !bus.hist_clr;
    assign bus.coef_wr_ready = w_idle;
    assign bus.m_axis_tvalid = (r_state == OUT);
    assign bus.m_axis_tdata  = r_out_data;
    assign bus.m_axis_tid    = r_out_tid;

    // Tap order: k=0 new sample, then x history, then y history (feedback pre-negated).
    always_comb begin
        w_opnd = r_x;
        for (int k = 1; k <= ORDER; k++) begin
            if (int'(r_tap) == k)         w_opnd = r_xh[r_ch][k-1];
            if (int'(r_tap) == k + ORDER) w_opnd = r_yh[r_ch][k-1];
        end
    end

    assign w_coef     = r_coef[r_ch][r_tap];
    assign w_prod     = w_opnd * w_coef;
    assign w_prod_ext = {{IW{w_prod[PW-1]}}, w_prod};
    assign w_sum      = r_acc + ((ROUND != 0) ? RND_ONE : '0);
    assign w_shr      = w_sum >>> COEFQ;

    always_comb begin
        if (w_shr > SAT_MAX)      w_sat = SAT_MAX[DW-1:0];
        else if (w_shr < SAT_MIN) w_sat = SAT_MIN[DW-1:0];
        else                      w_sat = w_shr[DW-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept && w_in_range)     w_state_next = MAC;
            MAC:  if (int'(r_tap) == N - 1)       w_state_next = RND;
            RND:                                  w_state_next = OUT;
            OUT:  if (bus.m_axis_tready)          w_state_next = IDLE;
            default:                              w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_x        <= '0;
            r_ch       <= '0;
            r_tap      <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_tid  <= '0;
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < N; k++)
                    r_coef[c][k] <= (k == 0) ? COEF_ONE : '0;
                for (int k = 0; k < ORDER; k++) begin
                    r_xh[c][k] <= '0;
                    r_yh[c][k] <= '0;
                end
            end
        end else begin
            r_state <= w_state_next;

            if (w_coef_we)
                r_coef[bus.coef_wr_ch][bus.coef_wr_idx] <= $signed(bus.coef_wr_data);

            if (w_idle && bus.hist_clr) begin
                for (int c = 0; c < NCH; c++) begin
                    for (int k = 0; k < ORDER; k++) begin
                        r_xh[c][k] <= '0;
                        r_yh[c][k] <= '0;
                    end
                end
            end

            // Out-of-range channels are handshaken but never latched.
            if (w_accept && w_in_range) begin
                r_x   <= $signed(bus.s_axis_tdata);
                r_ch  <= bus.s_axis_tid;
                r_tap <= '0;
            end

            if (r_state == MAC) begin
                r_tap <= r_tap + 1'b1;
                r_acc <= (r_tap == '0) ? w_prod_ext : r_acc + w_prod_ext;
            end

            if (r_state == RND) begin
                r_out_data <= w_sat;
                r_out_tid  <= r_ch;
                for (int k = ORDER - 1; k >= 1; k--) begin
                    r_xh[r_ch][k] <= r_xh[r_ch][k-1];
                    r_yh[r_ch][k] <= r_yh[r_ch][k-1];
                end
                r_xh[r_ch][0] <= r_x;
                r_yh[r_ch][0] <= w_sat;
            end
        end
    end
endmodule
